// File: rtl/seg7_scan_decoder.sv
// Recovers hex nibbles from a multiplexed active-low 7-segment bus, filtering scan
// glitches with a per-window stability counter and flagging a full refresh with VALID.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                      CLOCK_50,
  input  logic                      RESET,
  input  logic [6:0]                SEG,
  input  logic [NUM_DIGITS-1:0]     DIG_EN,
  output logic [4*NUM_DIGITS-1:0]   VALUE,
  output logic [NUM_DIGITS-1:0]     DIG_OK,
  output logic                      VALID,
  output logic                      ERR
);

  localparam logic [7:0] CAP_CNT = 8'(STABLE_CYCLES - 1);

  logic [6:0]            s_seg;
  logic [NUM_DIGITS-1:0] s_en;
  logic [7:0]            cnt;
  logic                  done;
  logic [NUM_DIGITS-1:0] mask;

  logic                  same;
  logic [NUM_DIGITS-1:0] sel;
  logic [3:0]            low_cnt;
  logic                  at_cap;
  logic                  capture;
  logic                  multi;
  logic                  glyph_ok;
  logic [3:0]            glyph_val;
  logic                  blank;
  logic [NUM_DIGITS-1:0] new_mask;
  logic                  mask_full;

  assign same      = ({SEG, DIG_EN} == {s_seg, s_en});
  assign sel       = ~s_en;
  assign at_cap    = (cnt == CAP_CNT);
  assign capture   = at_cap && !done && (low_cnt == 4'd1);
  assign multi     = at_cap && (low_cnt > 4'd1);
  assign blank     = (s_seg == 7'b1111111);
  assign new_mask  = mask | sel;
  assign mask_full = &new_mask;

  always_comb begin
    low_cnt = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      low_cnt = low_cnt + {3'b000, sel[i]};
    end
  end

  // Inverse of the encoder glyph table; anything else is not a hex digit.
  always_comb begin
    glyph_ok  = 1'b1;
    glyph_val = 4'h0;
    case (s_seg)
      7'b1000000: glyph_val = 4'h0;
      7'b1111001: glyph_val = 4'h1;
      7'b0100100: glyph_val = 4'h2;
      7'b0110000: glyph_val = 4'h3;
      7'b0011001: glyph_val = 4'h4;
      7'b0010010: glyph_val = 4'h5;
      7'b0000010: glyph_val = 4'h6;
      7'b1111000: glyph_val = 4'h7;
      7'b0000000: glyph_val = 4'h8;
      7'b0010000: glyph_val = 4'h9;
      7'b0001000: glyph_val = 4'hA;
      7'b0000011: glyph_val = 4'hB;
      7'b1000110: glyph_val = 4'hC;
      7'b0100001: glyph_val = 4'hD;
      7'b0000110: glyph_val = 4'hE;
      7'b0001110: glyph_val = 4'hF;
      default:    glyph_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      s_seg  <= '1;
      s_en   <= '1;
      cnt    <= '0;
      done   <= 1'b0;
      mask   <= '0;
      VALUE  <= '0;
      DIG_OK <= '0;
      VALID  <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      s_seg <= SEG;
      s_en  <= DIG_EN;
      VALID <= 1'b0;

      if (same) begin
        if (cnt != 8'hFF) cnt <= cnt + 8'd1;
      end else begin
        cnt <= '0;
      end

      if (capture) begin
        done <= 1'b1;
        if (mask_full) begin
          VALID <= 1'b1;
          mask  <= '0;
        end else begin
          mask <= new_mask;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (sel[k]) begin
            DIG_OK[k] <= glyph_ok;
            if (glyph_ok) VALUE[4*k +: 4] <= glyph_val;
          end
        end
      end

      // A changed sample starts a new window, even on the edge that captured the old one.
      if (!same) done <= 1'b0;

      if (multi || (capture && !glyph_ok && !blank)) ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed self-checking bench for seg7_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=4).
module tb_seg7_scan_decoder;

  logic        CLOCK_50;
  logic        RESET;
  logic [6:0]  SEG;
  logic [3:0]  DIG_EN;
  logic [15:0] VALUE;
  logic [3:0]  DIG_OK;
  logic        VALID;
  logic        ERR;

  int checks;
  int failures;
  int valid_pulses;

  seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .CLOCK_50(CLOCK_50),
    .RESET(RESET),
    .SEG(SEG),
    .DIG_EN(DIG_EN),
    .VALUE(VALUE),
    .DIG_OK(DIG_OK),
    .VALID(VALID),
    .ERR(ERR)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive the bus and advance n edges, sampling 1 time unit after each edge.
  task automatic applyStimulus(input logic [6:0] seg, input logic [3:0] en, input int n);
    SEG    = seg;
    DIG_EN = en;
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      #1;
      if (VALID === 1'b1) valid_pulses++;
    end
  endtask

  task automatic doReset();
    RESET = 1'b1;
    applyStimulus(7'b1111111, 4'b1111, 2);
    RESET = 1'b0;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    valid_pulses = 0;
    RESET  = 1'b1;
    SEG    = 7'b1111111;
    DIG_EN = 4'b1111;

    // Reset state
    doReset();
    checkOutput("rst_value", 32'(VALUE), 32'h0);
    checkOutput("rst_digok", 32'(DIG_OK), 32'h0);
    checkOutput("rst_valid", 32'(VALID), 32'h0);
    checkOutput("rst_err", 32'(ERR), 32'h0);

    // Latency: digit 0 shows 3; capture on the 5th edge only
    applyStimulus(7'b0110000, 4'b1110, 4);
    checkOutput("lat_digok_early", 32'(DIG_OK), 32'h0);
    checkOutput("lat_value_early", 32'(VALUE), 32'h0);
    applyStimulus(7'b0110000, 4'b1110, 1);
    checkOutput("lat_value", 32'(VALUE), 32'h0003);
    checkOutput("lat_digok", 32'(DIG_OK), 32'h1);
    checkOutput("lat_valid", 32'(VALID), 32'h0);
    valid_pulses = 0;
    applyStimulus(7'b0110000, 4'b1110, 20);
    checkOutput("hold_value", 32'(VALUE), 32'h0003);
    checkOutput("hold_digok", 32'(DIG_OK), 32'h1);
    checkOutput("hold_valid_pulses", 32'(valid_pulses), 32'h0);

    // Full scan A,1,b,7 on digits 3..0
    doReset();
    valid_pulses = 0;
    applyStimulus(7'b0001000, 4'b0111, 6);
    applyStimulus(7'b1111111, 4'b1111, 1);
    applyStimulus(7'b1111001, 4'b1011, 6);
    applyStimulus(7'b1111111, 4'b1111, 1);
    applyStimulus(7'b0000011, 4'b1101, 6);
    applyStimulus(7'b1111111, 4'b1111, 1);
    checkOutput("scan_no_valid_yet", 32'(valid_pulses), 32'h0);
    applyStimulus(7'b1111000, 4'b1110, 4);
    checkOutput("scan_valid_before", 32'(VALID), 32'h0);
    applyStimulus(7'b1111000, 4'b1110, 1);
    checkOutput("scan_valid_pulse", 32'(VALID), 32'h1);
    checkOutput("scan_value", 32'(VALUE), 32'hA1B7);
    checkOutput("scan_digok", 32'(DIG_OK), 32'hF);
    applyStimulus(7'b1111000, 4'b1110, 1);
    checkOutput("scan_valid_after", 32'(VALID), 32'h0);
    applyStimulus(7'b1111111, 4'b1111, 1);

    // Glitch: 2 for 2 cycles is rejected, 3 for 6 cycles captured
    applyStimulus(7'b0100100, 4'b1011, 2);
    checkOutput("glitch_reject", 32'(VALUE), 32'hA1B7);
    applyStimulus(7'b0110000, 4'b1011, 6);
    checkOutput("glitch_then_3", 32'(VALUE), 32'hA3B7);
    checkOutput("glitch_err", 32'(ERR), 32'h0);
    applyStimulus(7'b1111111, 4'b1111, 1);

    // Illegal glyph then blank glyph on digit 1
    applyStimulus(7'b1111110, 4'b1101, 6);
    checkOutput("illegal_digok", 32'(DIG_OK), 32'hD);
    checkOutput("illegal_err", 32'(ERR), 32'h1);
    checkOutput("illegal_value", 32'(VALUE), 32'hA3B7);
    applyStimulus(7'b1111111, 4'b1111, 1);
    applyStimulus(7'b1111111, 4'b1101, 6);
    checkOutput("blank_digok", 32'(DIG_OK), 32'hD);
    checkOutput("blank_err", 32'(ERR), 32'h1);
    checkOutput("blank_value", 32'(VALUE), 32'hA3B7);

    // Multi-digit strobe: sets ERR, leaves outputs and mask alone
    doReset();
    applyStimulus(7'b0010010, 4'b1110, 6);
    applyStimulus(7'b1111111, 4'b1111, 1);
    checkOutput("multi_pre_err", 32'(ERR), 32'h0);
    applyStimulus(7'b0000000, 4'b1100, 6);
    checkOutput("multi_err", 32'(ERR), 32'h1);
    checkOutput("multi_value", 32'(VALUE), 32'h0005);
    checkOutput("multi_digok", 32'(DIG_OK), 32'h1);
    applyStimulus(7'b1111111, 4'b1111, 1);
    valid_pulses = 0;
    applyStimulus(7'b1000110, 4'b1011, 6);
    applyStimulus(7'b1111111, 4'b1111, 1);
    applyStimulus(7'b0000110, 4'b0111, 6);
    applyStimulus(7'b1111111, 4'b1111, 1);
    checkOutput("multi_mask_untouched", 32'(valid_pulses), 32'h0);
    applyStimulus(7'b0100001, 4'b1101, 5);
    checkOutput("multi_valid_on_d1", 32'(VALID), 32'h1);
    checkOutput("multi_scan_value", 32'(VALUE), 32'hECD5);
    applyStimulus(7'b1111111, 4'b1111, 1);

    // Reset after three captures: the partial mask must be forgotten
    applyStimulus(7'b0001110, 4'b0111, 6);
    applyStimulus(7'b1111111, 4'b1111, 1);
    applyStimulus(7'b0000010, 4'b1011, 6);
    applyStimulus(7'b1111111, 4'b1111, 1);
    applyStimulus(7'b0011001, 4'b1101, 6);
    checkOutput("mid_value_pre_reset", 32'(VALUE), 32'hF645);
    doReset();
    checkOutput("mid_rst_value", 32'(VALUE), 32'h0);
    checkOutput("mid_rst_digok", 32'(DIG_OK), 32'h0);
    checkOutput("mid_rst_err", 32'(ERR), 32'h0);
    valid_pulses = 0;
    applyStimulus(7'b0010000, 4'b1110, 5);
    checkOutput("mid_d0_no_valid", 32'(VALID), 32'h0);
    checkOutput("mid_d0_value", 32'(VALUE), 32'h0009);
    applyStimulus(7'b1111111, 4'b1111, 1);
    applyStimulus(7'b1000000, 4'b1101, 6);
    applyStimulus(7'b1111111, 4'b1111, 1);
    applyStimulus(7'b0000000, 4'b1011, 6);
    applyStimulus(7'b1111111, 4'b1111, 1);
    checkOutput("mid_no_early_valid", 32'(valid_pulses), 32'h0);
    applyStimulus(7'b0100100, 4'b0111, 5);
    checkOutput("mid_valid_d3", 32'(VALID), 32'h1);
    checkOutput("mid_final_value", 32'(VALUE), 32'h2809);
    checkOutput("mid_final_digok", 32'(DIG_OK), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
